adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester operand pair present.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  unsigned/two's-complement operands.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1  operand pair accepted this cycle when valid and ready are both high.
REQ-007 SHALL have port rsp_valid  output  1  result present.
REQ-008 SHALL have port rsp_ready  input  1  consumer takes result this cycle when rsp_valid and rsp_ready are both high.
REQ-009 SHALL have port rsp_id  output  1  requester index of the result.
REQ-010 SHALL have ports rsp_s  output  5 (sum, bit 4 = carry), rsp_c  output  1 (carry out), rsp_o  output  1 (signed overflow = carry into bit 3 XOR carry out of bit 3).

Function
REQ-011 SHALL implement FSM states IDLE, CALC, RESP; IDLE->CALC on accept; CALC->RESP unconditionally; RESP->IDLE on rsp handshake with no accept; RESP->CALC on rsp handshake with same-cycle accept; otherwise RESP holds.
REQ-012 SHALL accept only in IDLE, or in RESP during the cycle rsp_valid and rsp_ready are both high; at most one requester accepted per cycle.
REQ-013 SHALL assert reqN_ready only for the granted requester, combinationally from state, valids, rsp_ready and the priority pointer; it never depends on the other requester's ready.
REQ-014 With RR_EN=1, SHALL grant the requester not served last when both are valid; the pointer updates only on accept; after reset requester 0 has priority.
REQ-015 With RR_EN=0, SHALL always grant requester 0 when both are valid.
REQ-016 SHALL capture the granted operands and index into operand registers on accept; the shared adder evaluates them in CALC; rsp_s/rsp_c/rsp_o/rsp_id are registered at the CALC->RESP edge.
REQ-017 Latency: rsp_valid SHALL rise 2 cycles after the accept edge; peak throughput is one result per 2 cycles.
REQ-018 rsp_valid SHALL be high exactly in RESP; rsp_* outputs SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-019 Arithmetic SHALL be 4+4 bit add, carry-in 0, rsp_s = {carry, sum[3:0]}, rsp_c = rsp_s[4].
REQ-020 Requester valid dropping without a handshake SHALL be ignored; no operand is taken from a non-granted requester.
REQ-021 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, rsp_valid 0, req0_ready and req1_ready 0, rsp_s 0, rsp_c 0, rsp_o 0, rsp_id 0, priority pointer to requester 0, and clear operand registers, including mid-CALC or mid-RESP (the in-flight result is discarded).
REQ-023 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-024 The FSM state encoding and the result width constant (5) SHALL reside in a shared package.
REQ-025 The adder datapath SHALL be one sub-module instance, four_bits_adder, driven from the operand registers; the arbiter and FSM stay in adder_arbiter.

Verification
REQ-026 Single request: req0 a=7, b=1 -> accept at edge N; rsp_valid at N+2 with rsp_s=01000, rsp_c=0, rsp_o=1, rsp_id=0.
REQ-027 Carry: req1 a=15, b=1 -> rsp_s=10000, rsp_c=1, rsp_o=0, rsp_id=1; a=8, b=8 -> rsp_s=10000, rsp_c=1, rsp_o=1.
REQ-028 Contention RR_EN=1: both valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1, one result every 2 cycles; with RR_EN=0 -> 0,0,0,0.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both reqN_ready=0; rsp_ready=1 with req pending -> same-cycle accept, RESP->CALC.
REQ-030 Reset in CALC with req0 a=3, b=4 in flight -> rsp_valid never rises for it; all outputs 0 during reset; the next request is granted to requester 0 when both are valid.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter.
//   state_t  : control FSM encoding (IDLE / CALC / RESP)
//   OP_W     : operand width
//   RES_W    : result width (sum plus carry)
//   op_t     : captured operand pair and requester index
//   res_t    : adder result bundle
package adder_arbiter_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic            id;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_t;

  typedef struct packed {
    logic [RES_W-1:0] s;
    logic             c;
    logic             o;
  } res_t;

endpackage

// File: rtl/four_bits_adder.sv
// Combinational 4+4 bit adder, carry-in 0.
//   a, b : operands (unsigned or two's complement)
//   s    : {carry, sum[3:0]}
//   c    : carry out of bit 3
//   o    : signed overflow (carry into bit 3 XOR carry out of bit 3)
module four_bits_adder
  import adder_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [RES_W-1:0] s,
  output logic             c,
  output logic             o
);

  logic [OP_W-1:0] lo;   // low three bits plus their carry into bit 3

  always_comb begin
    s  = {1'b0, a} + {1'b0, b};
    lo = {1'b0, a[OP_W-2:0]} + {1'b0, b[OP_W-2:0]};
    c  = s[RES_W-1];
    o  = lo[OP_W-1] ^ s[RES_W-1];
  end

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one registered adder.
//   clk, rst_n              : clock, async active-low reset
//   reqN_valid/a/b/ready    : requester N operand handshake
//   rsp_valid/ready         : result handshake
//   rsp_id                  : index of the requester that produced the result
//   rsp_s/rsp_c/rsp_o       : {carry,sum}, carry out, signed overflow
// Accept happens in IDLE, or in RESP in the same cycle the result is taken,
// giving one result every two cycles under full load.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [OP_W-1:0]  req0_a,
  input  logic [OP_W-1:0]  req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OP_W-1:0]  req1_a,
  input  logic [OP_W-1:0]  req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_s,
  output logic             rsp_c,
  output logic             rsp_o
);

  state_t state, state_nxt;
  logic   prio;       // 1 = requester 1 wins a tie (round-robin only)
  op_t    op_q;
  res_t   res_q;
  res_t   add_res;
  logic   acc_win, pick1, accept;

  // Gated by rst_n so ready is low for the whole reset interval, even
  // though the state register already reads IDLE.
  always_comb begin
    acc_win = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    if (req0_valid && req1_valid) pick1 = (RR_EN != 0) && prio;
    else                          pick1 = req1_valid;
    req0_ready = acc_win && req0_valid && !pick1;
    req1_ready = acc_win && req1_valid && pick1;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      op_q  <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Winner goes to the back of the line.
        prio    <= !pick1;
        op_q.id <= pick1;
        op_q.a  <= pick1 ? req1_a : req0_a;
        op_q.b  <= pick1 ? req1_b : req0_b;
      end
      if (state == CALC) res_q <= add_res;
    end
  end

  four_bits_adder u_add (
    .a (op_q.a),
    .b (op_q.b),
    .s (add_res.s),
    .c (add_res.c),
    .o (add_res.o)
  );

  // rsp_id is registered together with the result so it stays aligned
  // with it while op_q is reloaded by a same-cycle accept.
  logic id_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              id_q <= 1'b0;
    else if (state == CALC)  id_q <= op_q.id;
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_s     = res_q.s;
  assign rsp_c     = res_q.c;
  assign rsp_o     = res_q.o;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;

  logic       r0_ready, r1_ready, rv, rid, rc, ro;
  logic [4:0] rs;
  logic       f0_ready, f1_ready, fv, fid, fc, fo;
  logic [4:0] fs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1_ready),
    .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_id(rid),
    .rsp_s(rs), .rsp_c(rc), .rsp_o(ro)
  );

  adder_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(f0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(f1_ready),
    .rsp_valid(fv), .rsp_ready(rsp_ready), .rsp_id(fid),
    .rsp_s(fs), .rsp_c(fc), .rsp_o(fo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rv"},  {31'd0, rv},  0);
    chk({tag, "_rs"},  {27'd0, rs},  0);
    chk({tag, "_rc"},  {31'd0, rc},  0);
    chk({tag, "_ro"},  {31'd0, ro},  0);
    chk({tag, "_rid"}, {31'd0, rid}, 0);
    chk({tag, "_rdy"}, {30'd0, r1_ready, r0_ready}, 0);
    chk({tag, "_fp"},  {fv, fs, fid, f0_ready, f1_ready}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset");
    rst_n = 1'b1;
  endtask

  // Wait on negedges for rsp_valid of the round-robin DUT; returns cycles
  // counted from the accept edge.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rv && cyc < 10);
  endtask

  typedef struct {
    logic       id;
    logic [3:0] a, b;
    logic [4:0] s;
    logic       c, o;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc;
    int n_rr, n_fp;
    int id_rr[8], cyc_rr[8], id_fp[8];
    logic [4:0] hold_s;

    vecs[0] = '{0, 4'd7,  4'd1, 5'b01000, 0, 1};
    vecs[1] = '{1, 4'd15, 4'd1, 5'b10000, 1, 0};
    vecs[2] = '{1, 4'd8,  4'd8, 5'b10000, 1, 1};
    vecs[3] = '{0, 4'd3,  4'd4, 5'b00111, 0, 0};
    vecs[4] = '{0, 4'd15, 4'd15, 5'b11110, 1, 0};
    vecs[5] = '{1, 4'd4,  4'd4, 5'b01000, 0, 1};
    vecs[6] = '{0, 4'd0,  4'd0, 5'b00000, 0, 0};
    vecs[7] = '{1, 4'd9,  4'd6, 5'b01111, 0, 0};
    vecs[8] = '{0, 4'd8,  4'd15, 5'b10111, 1, 1};

    do_reset();

    // ---- single-request table ----
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      req0_valid = !vecs[i].id; req1_valid = vecs[i].id;
      req0_a = vecs[i].a; req0_b = vecs[i].b;
      req1_a = vecs[i].a; req1_b = vecs[i].b;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {30'd0, r1_ready, r0_ready},
          vecs[i].id ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      wait_rsp(cyc);
      chk($sformatf("v%0d_lat", i), cyc, 2);
      chk($sformatf("v%0d_s", i),  {27'd0, rs}, {27'd0, vecs[i].s});
      chk($sformatf("v%0d_co", i), {30'd0, rc, ro}, {30'd0, vecs[i].c, vecs[i].o});
      chk($sformatf("v%0d_id", i), {31'd0, rid}, {31'd0, vecs[i].id});
      chk($sformatf("v%0d_fp", i), {26'd0, fv, fs}, {26'd0, 1'b1, vecs[i].s});
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
    end

    // ---- contention: both valid, consumer always ready ----
    do_reset();
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2;   // 3
    req1_valid = 1; req1_a = 4'd5; req1_b = 4'd5;   // 10
    rsp_ready = 1;
    n_rr = 0; n_fp = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (rv && n_rr < 8) begin
        id_rr[n_rr] = rid; cyc_rr[n_rr] = k;
        chk($sformatf("cont_s%0d", n_rr), {27'd0, rs}, rid ? 32'd10 : 32'd3);
        n_rr++;
      end
      if (fv && n_fp < 8) begin
        id_fp[n_fp] = fid;
        n_fp++;
      end
    end
    chk("cont_n_rr", n_rr, 4);
    chk("cont_n_fp", n_fp, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr_id%0d", j), id_rr[j], j % 2);
      chk($sformatf("rr_cyc%0d", j), cyc_rr[j], 2 * (j + 1));
      chk($sformatf("fp_id%0d", j), id_fp[j], 0);
    end

    // ---- backpressure ----
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3;   // 5
    @(posedge clk); #1;
    req0_valid = 0;
    wait_rsp(cyc);
    chk("bp_lat", cyc, 2);
    hold_s = rs;
    chk("bp_first_s", {27'd0, rs}, 5);
    req1_valid = 1; req1_a = 4'd6; req1_b = 4'd1;   // 7
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {24'd0, rv, rid, r0_ready, r1_ready, rs},
          {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, hold_s});
    end
    rsp_ready = 1; #1;
    chk("bp_same_cycle_acc", {30'd0, r0_ready, r1_ready}, 1);
    @(posedge clk); #1;
    req1_valid = 0; rsp_ready = 0;
    @(negedge clk);
    chk("bp_calc_rv", {31'd0, rv}, 0);
    @(negedge clk);
    chk("bp_second", {24'd0, rv, rid, rc, ro, rs}, {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7});
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;

    // ---- reset while a request sits in CALC ----
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4;
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("rc_in_calc", {31'd0, rv}, 0);
    rst_n = 0;
    req0_valid = 1; req0_a = 4'd5; req0_b = 4'd5;   // 10
    req1_valid = 1; req1_a = 4'd1; req1_b = 4'd1;
    #1;
    chk_idle_outs("rc_async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rc_hold%0d", k), {30'd0, rv, r0_ready | r1_ready}, 0);
    end
    rst_n = 1; #1;
    chk("rc_grant0", {30'd0, r0_ready, r1_ready}, 2);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_rsp(cyc);
    chk("rc_lat", cyc, 2);
    chk("rc_res", {25'd0, rid, rc, ro, rs}, {25'd0, 1'b0, 1'b0, 1'b1, 5'b01010});
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
